// File: rtl/alarm_sequencer_if.sv
// RTC/alarm inputs, user buttons and melody-control outputs of the alarm sequencer.
interface alarm_sequencer_if;
  logic [7:0] rtc_hour;
  logic [7:0] rtc_min;
  logic [7:0] rtc_sec;
  logic [7:0] al_hour;
  logic [7:0] al_min;
  logic       al_enable;
  logic       btn_stop;
  logic       btn_snooze;
  logic       music_en;
  logic       music_rst;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_left;

  modport master (
    output rtc_hour, rtc_min, rtc_sec, al_hour, al_min, al_enable,
    output btn_stop, btn_snooze,
    input  music_en, music_rst, ringing, snoozing, snooze_left
  );

  modport slave (
    input  rtc_hour, rtc_min, rtc_sec, al_hour, al_min, al_enable,
    input  btn_stop, btn_snooze,
    output music_en, music_rst, ringing, snoozing, snooze_left
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm match, ring timeout, snooze and stop control upstream of the melody player.
module alarm_sequencer #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  localparam logic [15:0] RING_LAST   = 16'(RING_SECS - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SECS - 1);
  localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  left_q, left_d;
  logic [7:0]  sec_q;
  logic        armed_q, armed_d;
  logic        music_rst_q, music_rst_d;
  logic        music_en_q, ringing_q, snoozing_q;
  logic        sec_tick, match, stop_req;

  assign sec_tick = (bus.rtc_sec != sec_q);
  assign match    = bus.al_enable && (bus.rtc_hour == bus.al_hour) &&
                    (bus.rtc_min == bus.al_min) && (bus.rtc_sec == 8'h00) && armed_q;
  assign stop_req = !bus.al_enable || bus.btn_stop;

  // One trigger per matching minute: a match disarms even outside IDLE.
  always_comb begin
    armed_d = armed_q;
    if (bus.rtc_sec != 8'h00) begin
      armed_d = 1'b1;
    end else if (match) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    music_rst_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (match) begin
          state_d     = RING;
          cnt_d       = '0;
          left_d      = SNOOZE_MAX;
          music_rst_d = 1'b1;
        end
      end
      RING: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (bus.btn_snooze && (left_q != 4'd0)) begin
          state_d = SNOOZE;
          cnt_d   = '0;
          left_d  = left_q - 4'd1;
        end else if (bus.btn_snooze) begin
          state_d = RING;
        end else if (sec_tick) begin
          if (cnt_q == RING_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      SNOOZE: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d     = RING;
            cnt_d       = '0;
            music_rst_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      sec_q       <= 8'h00;
      armed_q     <= 1'b1;
      music_rst_q <= 1'b0;
      music_en_q  <= 1'b0;
      ringing_q   <= 1'b0;
      snoozing_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sec_q       <= bus.rtc_sec;
      armed_q     <= armed_d;
      music_rst_q <= music_rst_d;
      music_en_q  <= (state_d == RING);
      ringing_q   <= (state_d == RING);
      snoozing_q  <= (state_d == SNOOZE);
    end
  end

  assign bus.music_en    = music_en_q;
  assign bus.music_rst   = music_rst_q;
  assign bus.ringing     = ringing_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_left = left_q;

endmodule
